add_seq_mp: RTL and testbench
=============================

# add_seq_mp

Multi-precision add/subtract sequencer that time-shares one `cla32` 32-bit carry-lookahead adder to add or subtract two `32*WORDS`-bit operands. It processes one 32-bit word per cycle, least-significant word first, and holds the inter-word carry in a register. It sits beside `cla32` in the arithmetic datapath and gives the rest of the design a start/busy/done handshake.

## Interface
Parameters:
- `WORDS`, default 4: number of 32-bit words per operand (legal 2..16). Total width `W = 32*WORDS`.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `sub`  in  1  operation select: 0 gives `a+b`, 1 gives `a-b`; latched with `start`.
- `a`  in  W  operand A; latched with `start`.
- `b`  in  W  operand B; latched with `start`.
- `s`  out  W  result register.
- `co`  out  1  carry out of the MSB word. For subtract, 1 means no borrow.
- `ov`  out  1  signed two's-complement overflow.
- `busy`  out  1  high in CALC and DONE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- One internal `cla32` instance, with ports (s, co, a, b, ci):
  - a = current word of latched A.
  - b = current word of latched B, bitwise inverted when `sub`=1.
  - ci = carry register.
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC when `start`=1.
    - Latch `a`, `b` and `sub`.
    - Set word index `idx`=0.
    - Set carry register to `sub` (1 for subtract, forming the two's complement).
    - Clear `s`, `co` and `ov` to 0.
  - CALC: each cycle, write adder sum to `s[32*idx +: 32]`, load adder co into the carry register, and increment `idx`. When `idx`=WORDS-1, also do the following and go to DONE:
    - Write `co` from the adder co.
    - Write `ov` = carry into bit 31 XOR carry out of bit 31 of the top word. Equivalently, (A_msb == Beff_msb) && (S_msb != A_msb).
  - DONE → IDLE unconditionally after one cycle.
- `start` is ignored in CALC and DONE. No queuing; a request must be re-presented in IDLE.
- `s`, `co` and `ov` hold their final values from DONE until the next accepted `start`.
- `a`, `b` and `sub` may change freely after the accepting edge; only latched copies are used.
- `idx` is `$clog2(WORDS)` bits wide and never wraps mid-operation.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state = IDLE, `idx`=0, carry register = 0.
  - `s`=0, `co`=0, `ov`=0, `busy`=0, `done`=0.
  - Reset during CALC or DONE aborts the operation. Nothing resumes after release.
- Start accepted at edge E0.
  - CALC occupies the cycles after edges E0..E(WORDS-1).
  - Word k is written at edge E(k+1).
  - `done`=1 during the cycle after edge E(WORDS), which is the DONE state.
  - Latency from the accepting edge to `done` is WORDS+1 edges: 5 for WORDS=4.
- `busy` rises the cycle after E0 and falls the cycle after DONE. It is registered and asserted in CALC and DONE only.
- `start` held high continuously gives one operation every WORDS+2 cycles (IDLE, WORDS×CALC, DONE).
- All outputs are registered. The adder path is combinational within one cycle and must meet a 32-bit `cla32` delay.

## Test plan
1. WORDS=4, add, a=all-ones (128'hFFFF…F), b=1:
   - s=0, co=1, ov=0.
   - `done` is high exactly 5 edges after the accepting edge, for 1 cycle.
   - `busy` is high for 5 cycles.
2. Carry ripple across words. Add a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1:
   - s=128'h0000_0001_0000_0000_0000_0000_0000_0000, co=0, ov=0.
3. Subtract, a=5, b=7:
   - s=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, co=0 (borrow), ov=0.
   - Also a=7, b=5: s=2, co=1.
4. Signed overflow:
   - Add a=128'h7FFF…F, b=1: s=128'h8000_0…0, ov=1, co=0.
   - Subtract a=128'h8000_0…0, b=1: s=128'h7FFF…F, ov=1, co=1.
5. Robustness:
   - Pulse `start` with new operands during CALC: ignored, and the result matches the first operation.
   - Assert `reset_n`=0 mid-CALC: all outputs are 0 immediately, without waiting for a clock edge.
   - After release, a new add of 3+4 gives s=7.
6. Back-to-back with `start` held high and operands changed every cycle:
   - Operations are accepted every 6 cycles.
   - Each result corresponds to the operands present at its accepting edge.
   - `s` is stable between `done` and the next acceptance.

Source files
------------

// File: rtl/add_seq_mp.sv
// add_seq_mp: multi-precision add/subtract sequencer time-sharing one 32-bit CLA.
// Ports: clk, reset_n (async active-low); start/sub/a/b request and operands;
// s result, co carry out (1 = no borrow on subtract), ov signed overflow;
// busy high in CALC and DONE, done one-cycle pulse in DONE.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [31:0] x, g, p, cout;
  // Kogge-Stone prefix: after five doublings g/p cover bits [i:0].
  always_comb begin
    x = a ^ b;
    g = a & b;
    p = x;
    for (int l = 0; l < 5; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & ((p << (1 << l)) | ((32'd1 << (1 << l)) - 32'd1));
    end
    cout = g | (p & {32{ci}});
    s    = x ^ {cout[30:0], ci};
    co   = cout[31];
  end
endmodule

module add_seq_mp #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic [32*WORDS-1:0]   s,
  output logic                  co,
  output logic                  ov,
  output logic                  busy,
  output logic                  done
);
  localparam int W  = 32 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic            sub_q, sub_d, c_q, c_d, co_q, co_d, ov_q, ov_d, busy_q, done_q;
  logic [31:0]     aw, bw, sum;
  logic            cout;
  logic            last;

  assign aw   = a_q[32*idx_q +: 32];
  assign bw   = b_q[32*idx_q +: 32] ^ {32{sub_q}};
  assign last = idx_q == IW'(WORDS - 1);

  cla32 u_cla (.a(aw), .b(bw), .ci(c_q), .s(sum), .co(cout));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      idx_d   = '0;
      c_d     = sub;
      s_d     = '0;
      co_d    = 1'b0;
      ov_d    = 1'b0;
    end else if (state_q == CALC) begin
      s_d[32*idx_q +: 32] = sum;
      c_d   = cout;
      idx_d = last ? idx_q : idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        co_d    = cout;
        // Signed overflow: operands agree in sign but the sum does not.
        ov_d    = (aw[31] == bw[31]) && (sum[31] != aw[31]);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_add_seq_mp.sv
// tb_add_seq_mp: randomized self-checking bench for add_seq_mp against an arithmetic model.
module tb_add_seq_mp;
  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] s;
  logic         co, ov, busy, done;
  int           checks = 0;
  int           errors = 0;

  add_seq_mp #(.WORDS(WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b),
    .s(s), .co(co), .ov(ov), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                                output logic [W-1:0] rs, output logic rc, output logic rv);
    logic signed [W:0] r;
    logic [W:0]        u;
    r  = op ? $signed({x[W-1], x}) - $signed({y[W-1], y}) : $signed({x[W-1], x}) + $signed({y[W-1], y});
    u  = {1'b0, x} + {1'b0, y};
    rs = r[W-1:0];
    rv = r[W] ^ r[W-1];
    rc = op ? (x >= y) : u[W];
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op, input string name);
    logic [W-1:0] es;
    logic         ec, ev;
    int           n, bcnt;
    model(x, y, op, es, ec, ev);
    @(negedge clk);
    a = x; b = y; sub = op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = rnd(); b = rnd(); sub = ~op;
    n = 0; bcnt = 0;
    for (int k = 1; k <= 12 && n == 0; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) n = k;
    end
    checks++;
    if (n !== WORDS + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, WORDS + 1);
    end
    checks++;
    if ({s, co, ov} !== {es, ec, ev}) begin
      errors++;
      $display("FAIL %s result: s=%h co=%b ov=%b, expected s=%h co=%b ov=%b", name, s, co, ov, es, ec, ev);
    end
    @(negedge clk);
    if (busy) bcnt++;
    checks++;
    if (bcnt !== WORDS + 1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: busy cycles=%0d done=%b busy=%b, expected %0d 0 0", name, bcnt, done, busy, WORDS + 1);
    end
    checks++;
    if (s !== es) begin
      errors++;
      $display("FAIL %s hold: s=%h expected %h", name, s, es);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({s, co, ov, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: s=%h co=%b ov=%b busy=%b done=%b, expected all 0", s, co, ov, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op({W{1'b1}}, 1, 1'b0, "allones_plus1");
    do_op({64'h0, 64'hFFFF_FFFF_FFFF_FFFF} | (128'hFFFF_FFFF << 64), 1, 1'b0, "ripple");
    do_op(5, 7, 1'b1, "sub_5_7");
    do_op(7, 5, 1'b1, "sub_7_5");
    do_op({1'b0, {(W-1){1'b1}}}, 1, 1'b0, "ovf_add");
    do_op({1'b1, {(W-1){1'b0}}}, 1, 1'b1, "ovf_sub");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) do_op(rnd(), (i % 5 == 0) ? rnd() >> 64 : rnd(), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] x, y, es;
    logic         ec, ev;
    int           n;
    x = rnd(); y = rnd();
    model(x, y, 1'b0, es, ec, ev);
    @(negedge clk);
    a = x; b = y; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = rnd(); b = rnd(); sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 12 && n == 0; k++) begin
      if (done) n = 1;
      else @(negedge clk);
    end
    checks++;
    if (n != 1 || {s, co, ov} !== {es, ec, ev}) begin
      errors++;
      $display("FAIL ignore_start: done=%0d s=%h co=%b ov=%b, expected s=%h co=%b ov=%b", n, s, co, ov, es, ec, ev);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_requeue: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = {W{1'b1}}; b = '0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || s === '0) begin
      errors++;
      $display("FAIL midcalc_state: busy=%b s=%h, expected busy=1 and partial s", busy, s);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s, co, ov, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: s=%h co=%b ov=%b busy=%b done=%b, expected all 0", s, co, ov, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b expected 0", busy);
    end
    do_op(3, 4, 1'b0, "after_reset_3p4");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [0:17];
    logic [W-1:0] ob [0:17];
    logic         os [0:17];
    logic [W-1:0] es;
    logic         ec, ev;
    for (int e = 0; e < 18; e++) begin
      oa[e] = rnd(); ob[e] = rnd(); os[e] = 1'($urandom);
      a = oa[e]; b = ob[e]; sub = os[e]; start = (e < 17);
      @(posedge clk);
      @(negedge clk);
      if (e % 6 >= 4) model(oa[e - e % 6], ob[e - e % 6], os[e - e % 6], es, ec, ev);
      checks++;
      if (e % 6 == 4) begin
        if (done !== 1'b1 || {s, co, ov} !== {es, ec, ev}) begin
          errors++;
          $display("FAIL b2b_result edge %0d: done=%b s=%h co=%b ov=%b, expected done=1 s=%h co=%b ov=%b", e, done, s, co, ov, es, ec, ev);
        end
      end else if (e % 6 == 5) begin
        if (done !== 1'b0 || busy !== 1'b0 || s !== es) begin
          errors++;
          $display("FAIL b2b_hold edge %0d: done=%b busy=%b s=%h, expected 0 0 %h", e, done, busy, s, es);
        end
      end else if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_calc edge %0d: done=%b busy=%b, expected 0 1", e, done, busy);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
